// File: rtl/score_ram_reader_pkg.sv
// Shared definitions for the score RAM read side: record layout, FSM encoding,
// and small record-field helpers.
package score_ram_reader_pkg;

  // Record layout: {score[15:8], player_id[7:0]}
  localparam int unsigned SCORE_MSB = 15;
  localparam int unsigned SCORE_LSB = 8;
  localparam int unsigned ID_MSB    = 7;
  localparam int unsigned ID_LSB    = 0;

  localparam int unsigned SCORE_W = SCORE_MSB - SCORE_LSB + 1;
  localparam int unsigned ID_W    = ID_MSB - ID_LSB + 1;

  // A score of zero marks an unused RAM slot
  localparam logic [SCORE_W-1:0] EMPTY_SCORE = '0;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StConv,
    StDone
  } state_e;

  function automatic logic [SCORE_W-1:0] rec_score(input logic [15:0] rec);
    return rec[SCORE_MSB:SCORE_LSB];
  endfunction

  function automatic logic [ID_W-1:0] rec_id(input logic [15:0] rec);
    return rec[ID_MSB:ID_LSB];
  endfunction

endpackage

// File: rtl/score_ram_reader_bcd_seq.sv
// Sequential score-to-BCD converter: saturates the input on load, then peels off
// one ten per cycle. ready_o rises once the remainder is below ten.
module score_bcd_seq
  import score_ram_reader_pkg::*;
#(
  parameter logic [SCORE_W-1:0] MaxScore = 8'd99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic               ready_o,
  output logic [3:0]         tens_o,
  output logic [3:0]         ones_o
);

  localparam logic [SCORE_W-1:0] Ten = 8'd10;

  logic               run_q, run_d;
  logic [SCORE_W-1:0] val_q, val_d;
  logic [3:0]         tens_q, tens_d;

  // Conversion state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      val_q  <= '0;
      tens_q <= '0;
    end else begin
      run_q  <= run_d;
      val_q  <= val_d;
      tens_q <= tens_d;
    end
  end

  // Load saturates; each running cycle subtracts one ten until the remainder fits a digit
  always_comb begin
    run_d  = run_q;
    val_d  = val_q;
    tens_d = tens_q;
    if (load_i) begin
      run_d  = 1'b1;
      val_d  = (score_i > MaxScore) ? MaxScore : score_i;
      tens_d = '0;
    end else if (run_q) begin
      if (val_q >= Ten) begin
        val_d  = val_q - Ten;
        tens_d = tens_q + 4'd1;
      end else begin
        run_d = 1'b0;
      end
    end
  end

  // Digits are final whenever the remainder is a single digit
  always_comb begin
    ready_o = run_q && (val_q < Ten);
    tens_o  = tens_q;
    ones_o  = val_q[3:0];
  end

endmodule

// File: rtl/score_ram_reader.sv
// Scans the shared score RAM for the highest score and presents the leader's
// ID and BCD score digits. Yields the RAM port whenever the writer holds it.
module score_ram_reader
  import score_ram_reader_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_SCORE = 99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ram_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [7:0]        top_id,
  output logic [3:0]        top_score_tens,
  output logic [3:0]        top_score_ones
);

  // Pointer needs one extra bit so it can reach DEPTH (scan complete)
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PtrEnd = PTR_W'(DEPTH);

  state_e state_q, state_d;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               pending_q, pending_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [ID_W-1:0]    best_id_q, best_id_d;
  logic               best_valid_q, best_valid_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;

  logic               found_q, found_d;
  logic [7:0]         top_id_q, top_id_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;

  logic               issue;
  logic               scan_last;
  logic [SCORE_W-1:0] rd_score;
  logic [ID_W-1:0]    rd_id;
  logic               conv_ready;
  logic [SCORE_W-1:0] conv_score;
  logic [3:0]         conv_tens;
  logic [3:0]         conv_ones;

  assign rd_score  = rec_score(ram_dout);
  assign rd_id     = rec_id(ram_dout);
  assign issue     = (state_q == StScan) && !ram_busy && (ptr_q < PtrEnd);
  // Last SCAN cycle: every address issued, the final read is captured this cycle
  assign scan_last = (state_q == StScan) && (ptr_q == PtrEnd);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StScan;
      StScan: if (scan_last) state_d = StConv;
      StConv: if (conv_ready) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    ram_rw = 1'b0;
  end

  // Scan and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      pending_q    <= 1'b0;
      best_score_q <= '0;
      best_id_q    <= '0;
      best_valid_q <= 1'b0;
      ram_addr_q   <= '0;
      found_q      <= 1'b0;
      top_id_q     <= '0;
      tens_q       <= '0;
      ones_q       <= '0;
    end else begin
      ptr_q        <= ptr_d;
      pending_q    <= pending_d;
      best_score_q <= best_score_d;
      best_id_q    <= best_id_d;
      best_valid_q <= best_valid_d;
      ram_addr_q   <= ram_addr_d;
      found_q      <= found_d;
      top_id_q     <= top_id_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
    end
  end

  // Address follows the pointer while scanning and freezes once all reads are out
  always_comb begin
    ram_addr_d = ram_addr_q;
    if ((state_q == StScan) && (ptr_q < PtrEnd)) begin
      ram_addr_d = ptr_q[ADDR_W-1:0];
    end
  end

  assign ram_addr = ram_addr_d;

  // Read issue, data capture and running maximum
  always_comb begin
    ptr_d        = ptr_q;
    pending_d    = pending_q;
    best_score_d = best_score_q;
    best_id_d    = best_id_q;
    best_valid_d = best_valid_q;
    if ((state_q == StIdle) && start) begin
      ptr_d        = '0;
      pending_d    = 1'b0;
      best_score_d = '0;
      best_id_d    = '0;
      best_valid_d = 1'b0;
    end else if (state_q == StScan) begin
      pending_d = issue;
      if (issue) begin
        ptr_d = ptr_q + PTR_W'(1);
      end
      // Strictly greater keeps the lowest address on ties
      if (pending_q && (rd_score != EMPTY_SCORE) && (rd_score > best_score_q)) begin
        best_score_d = rd_score;
        best_id_d    = rd_id;
        best_valid_d = 1'b1;
      end
    end
  end

  // Converter is loaded on the last SCAN cycle with the fully updated maximum
  assign conv_score = best_valid_d ? best_score_d : EMPTY_SCORE;

  score_bcd_seq #(
    .MaxScore (SCORE_W'(MAX_SCORE))
  ) u_bcd (
    .clk     (clk),
    .rst     (rst),
    .load_i  (scan_last),
    .score_i (conv_score),
    .ready_o (conv_ready),
    .tens_o  (conv_tens),
    .ones_o  (conv_ones)
  );

  // Displayed results change only when entering DONE, so they appear alongside done
  always_comb begin
    found_d  = found_q;
    top_id_d = top_id_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    if ((state_q == StConv) && conv_ready) begin
      found_d  = best_valid_q;
      top_id_d = best_valid_q ? best_id_q : '0;
      tens_d   = conv_tens;
      ones_d   = conv_ones;
    end
  end

  assign found          = found_q;
  assign top_id         = top_id_q;
  assign top_score_tens = tens_q;
  assign top_score_ones = ones_q;

endmodule

// File: tb/tb_score_ram_reader.sv
// Directed bench for score_ram_reader with a behavioural leader/latency model and
// a per-cycle output comparator.
module tb_score_ram_reader;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ram_busy;
  logic [4:0]  ram_addr;
  logic        ram_rw;
  logic [15:0] ram_dout;
  logic        busy;
  logic        done;
  logic        found;
  logic [7:0]  top_id;
  logic [3:0]  top_score_tens;
  logic [3:0]  top_score_ones;

  score_ram_reader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ram_busy       (ram_busy),
    .ram_addr       (ram_addr),
    .ram_rw         (ram_rw),
    .ram_dout       (ram_dout),
    .busy           (busy),
    .done           (done),
    .found          (found),
    .top_id         (top_id),
    .top_score_tens (top_score_tens),
    .top_score_ones (top_score_ones)
  );

  always #5 clk = ~clk;

  // Synchronous RAM; the writer's traffic shows up as junk while it owns the port
  logic [15:0] mem [DEPTH];
  always @(posedge clk) ram_dout <= ram_busy ? 16'hFFEE : mem[ram_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected state: current display values and the values after the running scan
  logic       exp_found;
  logic [7:0] exp_id;
  logic [3:0] exp_tens, exp_ones;
  logic       nxt_found;
  logic [7:0] nxt_id;
  logic [3:0] nxt_tens, nxt_ones;
  int         done_at = 0;
  bit         active = 1'b0;
  int         ncnt = 0;
  int         t0 = 0;
  int         k;
  logic       exp_busy, exp_done;

  // Leader search, saturation and cycle budget straight from the behavioural rules
  task automatic model(input int nbusy);
    int best = 0;
    int bid = 0;
    bit bv = 1'b0;
    int v;
    logic [15:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = mem[i];
      if (int'(w[15:8]) != 0 && int'(w[15:8]) > best) begin
        best = int'(w[15:8]);
        bid  = int'(w[7:0]);
        bv   = 1'b1;
      end
    end
    v = (best > 99) ? 99 : best;
    nxt_found = bv;
    nxt_id    = 8'(bid);
    nxt_tens  = 4'(v / 10);
    nxt_ones  = 4'(v % 10);
    // SCAN (DEPTH+1 plus stalls), CONV (tens+1), DONE (1)
    done_at = DEPTH + 1 + nbusy + (v / 10 + 1) + 1;
  endtask

  // Per-cycle comparator, sampled on the falling edge
  always @(negedge clk) begin
    ncnt++;
    chk("ram_rw", ram_rw, 0);
    if (rst) begin
      exp_found = 1'b0;
      exp_id    = '0;
      exp_tens  = '0;
      exp_ones  = '0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_found", found, 0);
      chk("rst_id", top_id, 0);
      chk("rst_tens", top_score_tens, 0);
      chk("rst_ones", top_score_ones, 0);
      chk("rst_addr", ram_addr, 0);
    end else begin
      k        = ncnt - t0;
      exp_busy = active && (k >= 1) && (k <= done_at);
      exp_done = active && (k == done_at);
      if (exp_done) begin
        exp_found = nxt_found;
        exp_id    = nxt_id;
        exp_tens  = nxt_tens;
        exp_ones  = nxt_ones;
      end
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("found", found, exp_found);
      chk("top_id", top_id, exp_id);
      chk("tens", top_score_tens, exp_tens);
      chk("ones", top_score_ones, exp_ones);
    end
  end

  // Addresses presented on cycles where a read can be issued
  logic [4:0] addr_q [$];
  always @(posedge clk) begin
    if (!rst && busy && !ram_busy) addr_q.push_back(ram_addr);
  end

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
  endtask

  task automatic load_s1();
    clear_mem();
    mem[3]  = {8'd45, 8'h12};
    mem[17] = {8'd88, 8'h07};
  endtask

  // Launch a scan; optional ram_busy burst and a stray start, both in k-cycle units
  task automatic run_scan(input int busy_at, input int nbusy, input int start_at);
    model(nbusy);
    addr_q.delete();
    start = 1'b1;
    @(posedge clk);
    t0     = ncnt;
    active = 1'b1;
    #1 start = 1'b0;
    for (int c = 1; c <= done_at + 2; c++) begin
      ram_busy = (busy_at != 0) && (c >= busy_at) && (c < busy_at + nbusy);
      start    = (start_at != 0) && (c == start_at);
      @(posedge clk);
      #1;
    end
    ram_busy = 1'b0;
    start    = 1'b0;
    active   = 1'b0;
    chk("addr_count_ge_depth", addr_q.size() >= DEPTH, 1);
    if (addr_q.size() >= DEPTH) begin
      for (int i = 0; i < DEPTH; i++) chk("addr_seq", addr_q[i], i);
    end
  endtask

  task automatic chk_out(input string tag, input logic f, input logic [7:0] id,
                         input logic [3:0] t, input logic [3:0] o);
    chk({tag, "_found"}, found, f);
    chk({tag, "_id"}, top_id, id);
    chk({tag, "_tens"}, top_score_tens, t);
    chk({tag, "_ones"}, top_score_ones, o);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    ram_busy = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic leader
    load_s1();
    run_scan(0, 0, 0);
    chk("s1_latency", done_at, 43);
    chk_out("s1", 1'b1, 8'h07, 4'd8, 4'd8);

    // 2: tie goes to the lower address; a start during SCAN is ignored
    clear_mem();
    mem[5]  = {8'd60, 8'h21};
    mem[20] = {8'd60, 8'h33};
    run_scan(0, 0, 5);
    chk_out("s2", 1'b1, 8'h21, 4'd6, 4'd0);

    // 3: empty RAM
    clear_mem();
    run_scan(0, 0, 0);
    chk("s3_latency", done_at, 35);
    chk_out("s3", 1'b0, 8'h00, 4'd0, 4'd0);

    // 4: saturation, compare on full score
    clear_mem();
    mem[0] = {8'd200, 8'h0A};
    mem[1] = {8'd150, 8'h0B};
    run_scan(0, 0, 0);
    chk("s4_latency", done_at, 44);
    chk_out("s4", 1'b1, 8'h0A, 4'd9, 4'd9);

    // 5: writer holds the port for five cycles mid-scan
    load_s1();
    run_scan(10, 5, 0);
    chk("s5_latency", done_at, 48);
    chk_out("s5", 1'b1, 8'h07, 4'd8, 4'd8);

    // 6: reset at the 10th SCAN cycle, then a clean rescan
    clear_mem();
    mem[9] = {8'd73, 8'h44};
    model(0);
    start = 1'b1;
    @(posedge clk);
    t0     = ncnt;
    active = 1'b1;
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    active = 1'b0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("s6_abort", 1'b0, 8'h00, 4'd0, 4'd0);
    run_scan(0, 0, 0);
    chk_out("s6", 1'b1, 8'h44, 4'd7, 4'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
